label_allocator: RTL and testbench
==================================

Name: label_allocator

Overview:
- Writer side of the label table: allocates contiguous data-memory regions and writes the (type, base, count) entries that the address decoder later checks accesses against.
- Takes one allocation request at a time from the instruction core (LIMM/label-define path).
- Assigns a base from a bump pointer, validates the request, writes the label table, and returns base or an error.
- Sits between the decode/execute stage and the label table write port.

Parameters:
- MEM_LIMIT, 65536, number of allocatable data-memory words; valid addresses are 0..MEM_LIMIT-1.
- BASE_INIT, 0, bump-pointer value after reset and after free_all.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  allocation request present
- req_ready  out  1  allocator can accept a request
- req_lbid  in  12  label id to define
- req_type  in  8  label type (LBTYPE_* code)
- req_count  in  16  element count requested
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_base  out  16  assigned base (0 on error)
- resp_err  out  2  0=OK, 1=bad type, 2=zero count, 3=out of memory
- lbt_we  out  1  label table write enable
- lbt_lbidw  out  12  label table write id
- lbt_typw  out  8  type written
- lbt_basew  out  16  base written
- lbt_countw  out  16  count written
- free_all  in  1  release all regions; bump pointer returns to BASE_INIT
- next_free  out  17  current bump pointer (debug/status)

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_base=0, resp_err=0, lbt_we=0, all lbt_* write buses 0, next_free=BASE_INIT.
- States: IDLE, CHECK, WRITE, RESP (plus CLEAR when the optional feature is compiled in).
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch lbid, type and count; go to CHECK.
- CHECK (1 cycle), in priority order:
  - type not in the valid set (VPTR, SINT/UINT 1/2/4/8/16/32, CODE; UNDEFINED is invalid) -> err=1;
  - else count==0 -> err=2;
  - else next_free + count > MEM_LIMIT, evaluated in 17-bit arithmetic with no wrap -> err=3;
  - else err=0.
  - err!=0 -> RESP; err==0 -> WRITE.
- WRITE (1 cycle):
  - lbt_we=1 with lbidw/typw/countw set from the latched request and basew=next_free[15:0].
  - next_free += count.
  - Next state: RESP (or CLEAR when the feature is enabled).
- RESP:
  - resp_valid=1.
  - resp_base = assigned base, or 0 on error.
  - Outputs hold until resp_ready; transfer on resp_valid && resp_ready, then IDLE.
- Latency: accepting cycle = T. OK response at T+3, lbt_we at T+2. Error response at T+2, and lbt_we never asserts.
- req_ready=0 in every state except IDLE; no request is lost or duplicated.
- A region ending exactly at MEM_LIMIT is OK. One word beyond it is err=3, and next_free is unchanged.
- Redefining an existing lbid is allowed: a new region is allocated, the table entry is overwritten, and the old region is leaked until free_all.
- free_all:
  - Honoured only in IDLE; ignored in other states.
  - If asserted with req_valid in the same cycle, free_all wins: next_free=BASE_INIT and the request is not accepted that cycle.
- reset mid-operation: aborts immediately to reset values; a pending lbt_we or response is dropped.

Optional Feature:
- Macro: LBALLOC_CLEAR_EN.
- Enabled:
  - Adds ports mem_we (out, 1), mem_addr (out, 16) and mem_wdata (out, 32).
  - After WRITE, state CLEAR emits one zero-write per cycle for addresses base..base+count-1; mem_wdata=0.
  - RESP follows the last write, so OK latency = T+3+count.
  - The region is guaranteed zeroed before resp_valid.
- Disabled: no CLEAR state and no mem_* ports; memory contents are undefined.

Decomposition:
- LBTYPE_* codes, the resp_err codes and the state encoding go in the shared header def.v.
- One sub-module, label_type_check: combinational type-validity check. The address decoder uses the same rule, so the valid type set is defined in one place.

Test Plan:
- Reset, then request lbid=3, type=CODE, count=6 -> lbt_we at T+2 with base=0 and count=6; resp OK base=0 at T+3; next_free=6.
- Second request lbid=4, type=SINT32, count=10 -> base=6, next_free=16. Then free_all, then lbid=5, count=1 -> base=0.
- type=UNDEFINED, count=4 -> resp_err=1 at T+2; no lbt_we; next_free unchanged. count=0 with type=UINT8 -> err=2.
- MEM_LIMIT=16, next_free=12: count=4 -> OK with base=12, next_free=16. Then count=1 -> err=3, next_free stays 16.
- Hold resp_ready=0 for 5 cycles -> resp_valid and data stable, req_ready=0 throughout. Raise resp_ready -> one transfer, back to IDLE.
- With LBALLOC_CLEAR_EN, count=3 at next_free=2 -> mem_we for 3 cycles at addresses 2,3,4 with data 0; resp_valid at T+6. Assert reset during CLEAR -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/label_allocator_pkg.sv
// Shared definitions for the label allocator: LBTYPE codes, response error codes, FSM states.
// The CLEAR state exists only when LBALLOC_CLEAR_EN is defined.
package label_allocator_pkg;

  localparam logic [7:0] LBTYPE_UNDEFINED = 8'h00;
  localparam logic [7:0] LBTYPE_VPTR      = 8'h01;
  localparam logic [7:0] LBTYPE_SINT1     = 8'h10;
  localparam logic [7:0] LBTYPE_SINT2     = 8'h11;
  localparam logic [7:0] LBTYPE_SINT4     = 8'h12;
  localparam logic [7:0] LBTYPE_SINT8     = 8'h13;
  localparam logic [7:0] LBTYPE_SINT16    = 8'h14;
  localparam logic [7:0] LBTYPE_SINT32    = 8'h15;
  localparam logic [7:0] LBTYPE_UINT1     = 8'h20;
  localparam logic [7:0] LBTYPE_UINT2     = 8'h21;
  localparam logic [7:0] LBTYPE_UINT4     = 8'h22;
  localparam logic [7:0] LBTYPE_UINT8     = 8'h23;
  localparam logic [7:0] LBTYPE_UINT16    = 8'h24;
  localparam logic [7:0] LBTYPE_UINT32    = 8'h25;
  localparam logic [7:0] LBTYPE_CODE      = 8'h30;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_TYPE = 2'd1,
    ERR_ZERO = 2'd2,
    ERR_OOM  = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_WRITE = 3'd2,
`ifdef LBALLOC_CLEAR_EN
    ST_CLEAR = 3'd3,
`endif
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/label_allocator_type_check.sv
// Combinational label-type validity check; the address decoder instantiates the same block
// so the set of legal types lives in one place.
module label_allocator_type_check
  import label_allocator_pkg::*;
(
  input  logic [7:0] type_i,
  output logic       valid_o
);

  always_comb begin
    valid_o = 1'b0;
    case (type_i)
      LBTYPE_VPTR,
      LBTYPE_SINT1, LBTYPE_SINT2, LBTYPE_SINT4,
      LBTYPE_SINT8, LBTYPE_SINT16, LBTYPE_SINT32,
      LBTYPE_UINT1, LBTYPE_UINT2, LBTYPE_UINT4,
      LBTYPE_UINT8, LBTYPE_UINT16, LBTYPE_UINT32,
      LBTYPE_CODE: valid_o = 1'b1;
      default:     valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/label_allocator.sv
// Label table writer: bump-pointer region allocation, request validation and table write.
// Define LBALLOC_CLEAR_EN to add zero-fill of each new region (mem_* ports, CLEAR state).
module label_allocator
  import label_allocator_pkg::*;
#(
  parameter int MEM_LIMIT = 65536,
  parameter int BASE_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [11:0] req_lbid,
  input  logic [7:0]  req_type,
  input  logic [15:0] req_count,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_base,
  output logic [1:0]  resp_err,
  output logic        lbt_we,
  output logic [11:0] lbt_lbidw,
  output logic [7:0]  lbt_typw,
  output logic [15:0] lbt_basew,
  output logic [15:0] lbt_countw,
  input  logic        free_all,
`ifdef LBALLOC_CLEAR_EN
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
`endif
  output logic [16:0] next_free
);

  localparam logic [16:0] MEM_LIMIT_W = 17'(MEM_LIMIT);
  localparam logic [16:0] BASE_INIT_W = 17'(BASE_INIT);

  state_e      state_q;
  logic [11:0] lbid_q;
  logic [7:0]  type_q;
  logic [15:0] count_q;
  logic [16:0] next_free_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [15:0] resp_base_q;
  logic [1:0]  resp_err_q;
  logic        lbt_we_q;
  logic [11:0] lbt_lbidw_q;
  logic [7:0]  lbt_typw_q;
  logic [15:0] lbt_basew_q;
  logic [15:0] lbt_countw_q;
`ifdef LBALLOC_CLEAR_EN
  logic        mem_we_q;
  logic [15:0] mem_addr_q;
  logic [15:0] clr_left_q;
`endif

  logic        type_ok;
  logic [16:0] nf_sum_d;
  err_e        chk_err_d;

  label_allocator_type_check u_type_check (
    .type_i  (type_q),
    .valid_o (type_ok)
  );

  // Sum cannot exceed 17 bits: next_free <= 65536 and count <= 65535.
  always_comb begin
    nf_sum_d  = next_free_q + {1'b0, count_q};
    chk_err_d = ERR_OK;
    if (!type_ok)                     chk_err_d = ERR_TYPE;
    else if (count_q == 16'd0)        chk_err_d = ERR_ZERO;
    else if (nf_sum_d > MEM_LIMIT_W)  chk_err_d = ERR_OOM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lbid_q       <= '0;
      type_q       <= '0;
      count_q      <= '0;
      next_free_q  <= BASE_INIT_W;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_base_q  <= '0;
      resp_err_q   <= '0;
      lbt_we_q     <= 1'b0;
      lbt_lbidw_q  <= '0;
      lbt_typw_q   <= '0;
      lbt_basew_q  <= '0;
      lbt_countw_q <= '0;
`ifdef LBALLOC_CLEAR_EN
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      clr_left_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // free_all takes priority over a simultaneous request.
          if (free_all) begin
            next_free_q <= BASE_INIT_W;
          end else if (req_valid) begin
            lbid_q      <= req_lbid;
            type_q      <= req_type;
            count_q     <= req_count;
            req_ready_q <= 1'b0;
            state_q     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_err_d != ERR_OK) begin
            resp_valid_q <= 1'b1;
            resp_base_q  <= '0;
            resp_err_q   <= chk_err_d;
            state_q      <= ST_RESP;
          end else begin
            lbt_we_q     <= 1'b1;
            lbt_lbidw_q  <= lbid_q;
            lbt_typw_q   <= type_q;
            lbt_basew_q  <= next_free_q[15:0];
            lbt_countw_q <= count_q;
            state_q      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          lbt_we_q    <= 1'b0;
          next_free_q <= nf_sum_d;
`ifdef LBALLOC_CLEAR_EN
          mem_we_q    <= 1'b1;
          mem_addr_q  <= lbt_basew_q;
          clr_left_q  <= count_q - 16'd1;
          state_q     <= ST_CLEAR;
`else
          resp_valid_q <= 1'b1;
          resp_base_q  <= lbt_basew_q;
          resp_err_q   <= ERR_OK;
          state_q      <= ST_RESP;
`endif
        end
`ifdef LBALLOC_CLEAR_EN
        ST_CLEAR: begin
          if (clr_left_q == 16'd0) begin
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_base_q  <= lbt_basew_q;
            resp_err_q   <= ERR_OK;
            state_q      <= ST_RESP;
          end else begin
            mem_addr_q <= mem_addr_q + 16'd1;
            clr_left_q <= clr_left_q - 16'd1;
          end
        end
`endif
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_base  = resp_base_q;
  assign resp_err   = resp_err_q;
  assign lbt_we     = lbt_we_q;
  assign lbt_lbidw  = lbt_lbidw_q;
  assign lbt_typw   = lbt_typw_q;
  assign lbt_basew  = lbt_basew_q;
  assign lbt_countw = lbt_countw_q;
  assign next_free  = next_free_q;
`ifdef LBALLOC_CLEAR_EN
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = 32'd0;
`endif

endmodule

// File: tb/tb_label_allocator.sv
// Scoreboard bench for label_allocator with a 16-word memory; covers allocation, errors,
// free_all, backpressure and mid-operation reset (zero-fill checks when LBALLOC_CLEAR_EN is set).
module tb_label_allocator;
  import label_allocator_pkg::*;

  localparam int MEM_LIMIT = 16;

  typedef struct {
    logic [15:0] base;
    logic [1:0]  err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [11:0] lbid;
    logic [7:0]  typ;
    logic [15:0] base;
    logic [15:0] count;
  } lbt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [11:0] req_lbid = '0;
  logic [7:0]  req_type = '0;
  logic [15:0] req_count = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_base;
  logic [1:0]  resp_err;
  logic        lbt_we;
  logic [11:0] lbt_lbidw;
  logic [7:0]  lbt_typw;
  logic [15:0] lbt_basew;
  logic [15:0] lbt_countw;
  logic        free_all = 1'b0;
  logic [16:0] next_free;
`ifdef LBALLOC_CLEAR_EN
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
`endif

  int checks = 0;
  int errors = 0;
  int nf_model = 0;
  resp_t resp_q[$];
  lbt_t  lbt_q[$];

  always #5 clk = ~clk;

  label_allocator #(.MEM_LIMIT(MEM_LIMIT), .BASE_INIT(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lbid   (req_lbid),
    .req_type   (req_type),
    .req_count  (req_count),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_base  (resp_base),
    .resp_err   (resp_err),
    .lbt_we     (lbt_we),
    .lbt_lbidw  (lbt_lbidw),
    .lbt_typw   (lbt_typw),
    .lbt_basew  (lbt_basew),
    .lbt_countw (lbt_countw),
    .free_all   (free_all),
`ifdef LBALLOC_CLEAR_EN
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
`endif
    .next_free  (next_free)
  );

  function automatic bit tb_type_ok(input logic [7:0] t);
    return t inside {8'h01, [8'h10:8'h15], [8'h20:8'h25], 8'h30};
  endfunction

  task automatic check_idle_outputs(input string name);
    logic clr_busy;
    clr_busy = 1'b0;
`ifdef LBALLOC_CLEAR_EN
    clr_busy = mem_we;
`endif
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_base !== 16'd0 || resp_err !== 2'd0 ||
        lbt_we !== 1'b0 || lbt_lbidw !== 12'd0 || lbt_typw !== 8'd0 || lbt_basew !== 16'd0 ||
        lbt_countw !== 16'd0 || next_free !== 17'd0 || clr_busy !== 1'b0)
    begin
      errors++;
      $display("FAIL %s: got rdy=%b rv=%b base=%h err=%0d we=%b lbt=%h/%h/%h/%h nf=%0d clr=%b want rdy=1 rest 0",
               name, req_ready, resp_valid, resp_base, resp_err, lbt_we, lbt_lbidw, lbt_typw,
               lbt_basew, lbt_countw, next_free, clr_busy);
    end
  endtask

  // Drives one request, predicts its outcome, and checks table write, zero-fill and response.
  task automatic alloc(input logic [11:0] lbid, input logic [7:0] typ, input logic [15:0] cnt,
                       input int hold);
    resp_t r;
    resp_t got;
    lbt_t  w;
    int    n;
    int    clr_k;
    bit    done;
    r.base = 16'd0;
    r.err  = 2'd0;
    r.lat  = 2;
    if (!tb_type_ok(typ))               r.err = 2'd1;
    else if (cnt == 16'd0)              r.err = 2'd2;
    else if (nf_model + int'(cnt) > MEM_LIMIT) r.err = 2'd3;
    if (r.err == 2'd0) begin
      r.base = 16'(nf_model);
      r.lat  = 3;
`ifdef LBALLOC_CLEAR_EN
      r.lat  = 3 + int'(cnt);
`endif
      w = '{lbid, typ, 16'(nf_model), cnt};
      lbt_q.push_back(w);
      nf_model += int'(cnt);
    end
    resp_q.push_back(r);

    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_lbid  = lbid;
    req_type  = typ;
    req_count = cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;

    n = 0;
    clr_k = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (lbt_we === 1'b1) begin
        checks++;
        if (lbt_q.size() == 0) begin
          errors++;
          $display("FAIL lbt_we_spurious: got lbt_we=1 at +%0d want no write (err=%0d)", n, r.err);
        end else begin
          w = lbt_q.pop_front();
          if (lbt_lbidw !== w.lbid || lbt_typw !== w.typ || lbt_basew !== w.base ||
              lbt_countw !== w.count || n != 2) begin
            errors++;
            $display("FAIL lbt_write: got id=%h typ=%h base=%0d cnt=%0d at +%0d want id=%h typ=%h base=%0d cnt=%0d at +2",
                     lbt_lbidw, lbt_typw, lbt_basew, lbt_countw, n, w.lbid, w.typ, w.base, w.count);
          end
        end
      end
`ifdef LBALLOC_CLEAR_EN
      if (mem_we === 1'b1) begin
        checks++;
        if (r.err != 2'd0 || clr_k >= int'(cnt) || mem_addr !== r.base + 16'(clr_k) ||
            mem_wdata !== 32'd0 || n != 3 + clr_k) begin
          errors++;
          $display("FAIL clear_write: got addr=%0d data=%h at +%0d want addr=%0d data=0 at +%0d",
                   mem_addr, mem_wdata, n, r.base + 16'(clr_k), 3 + clr_k);
        end
        clr_k++;
      end
`endif
      if (resp_valid === 1'b1) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_spurious: got resp_valid=1 want none");
          done = 1'b1;
        end else begin
          got = resp_q.pop_front();
          if (resp_base !== got.base || resp_err !== got.err || n != got.lat) begin
            errors++;
            $display("FAIL resp: got base=%0d err=%0d at +%0d want base=%0d err=%0d at +%0d",
                     resp_base, resp_err, n, got.base, got.err, got.lat);
          end
          for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_base !== got.base || resp_err !== got.err ||
                req_ready !== 1'b0) begin
              errors++;
              $display("FAIL resp_hold: got rv=%b base=%0d err=%0d rdy=%b want rv=1 base=%0d err=%0d rdy=0",
                       resp_valid, resp_base, resp_err, req_ready, got.base, got.err);
            end
            free_all = (h == 1);
          end
          free_all   = 1'b0;
          resp_ready = 1'b1;
          @(posedge clk);
          #1 resp_ready = 1'b0;
          @(negedge clk);
          checks++;
          if (resp_valid !== 1'b0 || req_ready !== 1'b1 || next_free !== 17'(nf_model)) begin
            errors++;
            $display("FAIL post_transfer: got rv=%b rdy=%b nf=%0d want rv=0 rdy=1 nf=%0d",
                     resp_valid, req_ready, next_free, nf_model);
          end
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got no response in 80 cycles want err=%0d", r.err);
    end
    if (lbt_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL lbt_missing: got %0d pending writes want 0", lbt_q.size());
    end
    resp_q.delete();
    lbt_q.delete();
  endtask

  task automatic do_free_all();
    @(negedge clk);
    free_all = 1'b1;
    @(posedge clk);
    #1 free_all = 1'b0;
    nf_model = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_state");
  endtask

  task automatic test_alloc();
    alloc(12'd3, LBTYPE_CODE, 16'd6, 0);
    alloc(12'd4, LBTYPE_SINT32, 16'd10, 0);
  endtask

  task automatic test_free_all();
    // free_all together with a request: pointer resets, request is not taken.
    @(negedge clk);
    free_all  = 1'b1;
    req_valid = 1'b1;
    req_lbid  = 12'd9;
    req_type  = LBTYPE_UINT8;
    req_count = 16'd2;
    @(posedge clk);
    #1 free_all = 1'b0;
    req_valid = 1'b0;
    nf_model = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (next_free !== 17'd0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || lbt_we !== 1'b0) begin
        errors++;
        $display("FAIL free_all_collision: got nf=%0d rdy=%b rv=%b we=%b want nf=0 rdy=1 rv=0 we=0",
                 next_free, req_ready, resp_valid, lbt_we);
      end
    end
    alloc(12'd5, LBTYPE_UINT16, 16'd1, 0);
  endtask

  task automatic test_errors();
    alloc(12'd7, LBTYPE_UNDEFINED, 16'd4, 0);
    alloc(12'd8, LBTYPE_UINT8, 16'd0, 0);
    alloc(12'd9, 8'hFF, 16'd0, 0);
    alloc(12'd5, LBTYPE_VPTR, 16'd2, 0);
  endtask

  task automatic test_boundary();
    alloc(12'd10, LBTYPE_UINT1, 16'd9, 0);
    alloc(12'd11, LBTYPE_SINT1, 16'd4, 0);
    alloc(12'd12, LBTYPE_UINT32, 16'd1, 0);
    do_free_all();
    alloc(12'd13, LBTYPE_SINT16, 16'hFFFF, 0);
  endtask

  task automatic test_backpressure();
    do_free_all();
    alloc(12'd20, LBTYPE_SINT2, 16'd5, 5);
  endtask

`ifdef LBALLOC_CLEAR_EN
  task automatic test_clear();
    do_free_all();
    alloc(12'd30, LBTYPE_UINT4, 16'd2, 0);
    alloc(12'd31, LBTYPE_UINT4, 16'd3, 0);
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_lbid  = 12'h077;
    req_type  = LBTYPE_SINT4;
    req_count = 16'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
`ifdef LBALLOC_CLEAR_EN
    repeat (4) @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got mem_we=%b want 1", mem_we);
    end
`else
    repeat (2) @(negedge clk);
    checks++;
    if (lbt_we !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_busy: got lbt_we=%b want 1", lbt_we);
    end
`endif
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    nf_model = 0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_free_all();
    test_errors();
    test_boundary();
    test_backpressure();
`ifdef LBALLOC_CLEAR_EN
    test_clear();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
